// File: rtl/branch_ctrl.sv
// Branch resolution controller for the EX stage.
// Accepts one conditional branch at a time over a valid/ready handshake.
// The operands and sign mode go out to the shared branch_comp comparator
// from registered copies. The comparator's result is decoded against funct3.
// A taken, aligned branch produces a one-cycle redirect and a multi-cycle
// flush. Saturating counters record how many branches resolved and were taken.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   br_valid / br_ready           branch request handshake (ready iff IDLE)
//   br_funct3, br_pc, br_imm      B-type funct3, branch PC, sign-extended imm
//   br_rs1, br_rs2                register operands
//   cmp_sign_select               to comparator: 1 signed, 0 unsigned
//   cmp_rdata1, cmp_rdata2        to comparator: latched operands
//   cmp_equal, cmp_less_than      from comparator (combinational)
//   resolve_valid, taken          resolve pulse and held decision
//   redirect_valid, redirect_pc   fetch redirect pulse and held target
//   flush                         squash younger IF/ID instructions
//   br_illegal, br_misalign       fault pulses
//   stat_resolved, stat_taken     saturating statistics
module branch_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  output logic            cmp_sign_select,
  output logic [XLEN-1:0] cmp_rdata1,
  output logic [XLEN-1:0] cmp_rdata2,
  input  logic            cmp_equal,
  input  logic            cmp_less_than,
  output logic            resolve_valid,
  output logic            taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            br_illegal,
  output logic            br_misalign,
  output logic [15:0]     stat_resolved,
  output logic [15:0]     stat_taken
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX   = '1;
  localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   pc_q, imm_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              decision_c, illegal_c, misalign_c;
  logic [XLEN-1:0]   target_c;

  logic              resolve_valid_d, taken_d, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_d;
  logic              flush_d, br_ready_d, br_illegal_d, br_misalign_d;
  logic [STAT_W-1:0] stat_resolved_d, stat_taken_d;

  // br_ready is a registered copy of (state == IDLE)
  assign accept = br_valid && br_ready;

  // Branch decision from the comparator result and the latched funct3
  always_comb begin
    decision_c = 1'b0;
    illegal_c  = 1'b0;
    unique case (funct3_q)
      3'b000:          decision_c = cmp_equal;
      3'b001:          decision_c = !cmp_equal;
      3'b100, 3'b110:  decision_c = cmp_less_than;
      3'b101, 3'b111:  decision_c = !cmp_less_than;
      default:         illegal_c  = 1'b1;
    endcase
    target_c   = pc_q + imm_q;
    misalign_c = decision_c && (target_c[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = COMPARE;
      COMPARE: state_d = (decision_c && !misalign_c) ? FLUSH : IDLE;
      FLUSH:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the flush counter
  always_comb begin
    resolve_valid_d  = 1'b0;
    taken_d          = taken;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc;
    br_illegal_d     = 1'b0;
    br_misalign_d    = 1'b0;
    cnt_d            = cnt_q;
    stat_resolved_d  = stat_resolved;
    stat_taken_d     = stat_taken;
    flush_d          = (state_d == FLUSH);
    br_ready_d       = (state_d == IDLE);
    unique case (state_q)
      COMPARE: begin
        resolve_valid_d = 1'b1;
        taken_d         = decision_c;
        br_illegal_d    = illegal_c;
        br_misalign_d   = misalign_c;
        if (decision_c && !misalign_c) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target_c;
          cnt_d            = FLUSH_LOAD;
        end
        if (!illegal_c && (stat_resolved != STAT_MAX))
          stat_resolved_d = stat_resolved + STAT_W'(1);
        if (decision_c && (stat_taken != STAT_MAX))
          stat_taken_d = stat_taken + STAT_W'(1);
      end
      FLUSH: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_valid  <= 1'b0;
      taken          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      br_ready       <= 1'b1;
      br_illegal     <= 1'b0;
      br_misalign    <= 1'b0;
      cnt_q          <= '0;
      stat_resolved  <= '0;
      stat_taken     <= '0;
    end else begin
      resolve_valid  <= resolve_valid_d;
      taken          <= taken_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      flush          <= flush_d;
      br_ready       <= br_ready_d;
      br_illegal     <= br_illegal_d;
      br_misalign    <= br_misalign_d;
      cnt_q          <= cnt_d;
      stat_resolved  <= stat_resolved_d;
      stat_taken     <= stat_taken_d;
    end
  end

  // Request capture; comparator drive holds its value until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q        <= '0;
      pc_q            <= '0;
      imm_q           <= '0;
      cmp_rdata1      <= '0;
      cmp_rdata2      <= '0;
      cmp_sign_select <= 1'b0;
    end else if (accept) begin
      funct3_q        <= br_funct3;
      pc_q            <= br_pc;
      imm_q           <= br_imm;
      cmp_rdata1      <= br_rs1;
      cmp_rdata2      <= br_rs2;
      // 110/111 (BLTU/BGEU) are the only unsigned compares
      cmp_sign_select <= !(br_funct3[2] && br_funct3[1]);
    end
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller wrapping the shared `branch_comp` comparator in the EX stage. It accepts one conditional branch at a time over a valid/ready handshake and drives the comparator's operands and `sign_select` from registered copies. It decodes `equal`/`less_than` against funct3, computes the target, and issues a one-cycle redirect plus a multi-cycle pipeline flush for taken branches. It also keeps saturating resolution statistics.

## Interface
- `XLEN`, 32, datapath/PC width
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a taken branch (legal range 1..15)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `br_valid`  in  1  branch request present
- `br_ready`  out  1  controller can accept; high iff state IDLE
- `br_funct3`  in  3  RV32I B-type funct3
- `br_pc`  in  XLEN  PC of the branch
- `br_imm`  in  XLEN  sign-extended B-immediate
- `br_rs1`, `br_rs2`  in  XLEN  register operands
- `cmp_sign_select`  out  1  to `branch_comp`: 1 = signed compare, 0 = unsigned
- `cmp_rdata1`, `cmp_rdata2`  out  XLEN  to `branch_comp` operands
- `cmp_equal`, `cmp_less_than`  in  1  from `branch_comp` (combinational)
- `resolve_valid`  out  1  one-cycle pulse: a branch finished resolving
- `taken`  out  1  result qualified by `resolve_valid`
- `redirect_valid`  out  1  one-cycle pulse: fetch must jump to `redirect_pc`
- `redirect_pc`  out  XLEN  branch target
- `flush`  out  1  squash younger IF/ID instructions
- `br_illegal`  out  1  one-cycle pulse: funct3 010/011
- `br_misalign`  out  1  one-cycle pulse: taken target with bits[1:0] != 0
- `stat_resolved`, `stat_taken`  out  16  saturating counters

## Operation
- **States:** IDLE, COMPARE, FLUSH.
- **IDLE:**
  - On a clock edge with `br_valid && br_ready`, latch funct3, pc, imm, rs1 and rs2; go to COMPARE.
- **Comparator drive:**
  - `cmp_rdata1`/`cmp_rdata2` come directly from the latched rs1/rs2 registers.
  - `cmp_sign_select` = 0 for funct3 110/111, otherwise 1.
  - All three hold their last latched value outside COMPARE.
- **COMPARE:** decode the comparator outputs by funct3:
  - 000 BEQ: `eq`
  - 001 BNE: `!eq`
  - 100 BLT and 110 BLTU: `lt`
  - 101 BGE and 111 BGEU: `!lt`
  - 010/011: not taken; pulse `br_illegal`
- **Target:** `pc + imm` mod 2^XLEN; overflow wraps silently.
- **COMPARE exit (registered at the end of the COMPARE cycle):**
  - Always: `resolve_valid` = 1 and `taken` = decision.
  - Taken, target aligned: `redirect_valid` = 1, `redirect_pc` = target, `flush` = 1; load the flush counter with `FLUSH_CYCLES`-1; go to FLUSH.
  - Taken, target misaligned: `br_misalign` = 1, no redirect, no flush; go to IDLE.
  - Not taken or illegal: go to IDLE.
- **FLUSH:**
  - `flush` stays high and `redirect_valid` drops after one cycle.
  - The counter decrements each cycle; at 0, `flush` falls and the state returns to IDLE.
- **Statistics** update on the `resolve_valid` edge:
  - `stat_resolved` +1 for non-illegal branches.
  - `stat_taken` +1 when `taken` (including misaligned).
  - Both saturate at 0xFFFF.
- `br_valid` while `br_ready` = 0 is ignored; the requester must hold it.

## Timing
- **Reset:**
  - State IDLE.
  - All pulses, `flush`, `taken`, `redirect_pc`, `cmp_*` outputs and both stat counters are 0.
  - `br_ready` reads 1.
  - Reset takes effect immediately, including mid-COMPARE or mid-FLUSH; `flush` drops asynchronously.
- **Latency (accept at edge of cycle N):**
  - COMPARE occupies N+1.
  - `resolve_valid`, `taken` and `redirect_valid` are high in N+2.
- **Not-taken path:** `br_ready` = 1 again in N+2; back-to-back branches gives throughput 1 per 2 cycles.
- **Taken path:**
  - `flush` is high N+2 .. N+1+`FLUSH_CYCLES`.
  - `br_ready` is 1 at N+2+`FLUSH_CYCLES`.
- **Held outputs:** `redirect_pc` and `taken` hold until the next resolve.
- **Combinational paths:** the only combinational input-to-state path is `cmp_equal`/`cmp_less_than` to the COMPARE registers; no input reaches any output combinationally.

## Test plan
- **BEQ equal:** BEQ, rs1 = rs2 = 20, pc 0x100, imm 0x10 → `cmp_sign_select` = 1 in COMPARE, `taken` = 1, `redirect_pc` = 0x110 at N+2, `flush` high 2 cycles, `br_ready` back at N+4.
- **Signed vs unsigned:**
  - BLT, rs1 = 0xffff0000, rs2 = 0xffffffff → taken.
  - BLTU, rs1 = 0x0fff0000, rs2 = 0xffffffff → taken, `cmp_sign_select` = 0.
  - BLT with the same operands → not taken, `br_ready` back at N+2, no `flush`.
- **BGE and BNE:** BGE, rs1 = 30, rs2 = 20 → taken; BNE, rs1 = rs2 = 20 → not taken. After both, `stat_resolved` = 2 and `stat_taken` = 1.
- **Faults:**
  - funct3 = 010 → `br_illegal` pulse, `taken` = 0, stats unchanged.
  - BEQ taken with pc 0x100, imm 0x2 → `br_misalign` pulse, no `redirect_valid`/`flush`.
  - pc 0xfffffff0, imm 0x20 → `redirect_pc` = 0x10 (wrap).
- **Reset and handshake:**
  - Assert `rst_n` = 0 one cycle into FLUSH → `flush` = 0 immediately, state IDLE, stats 0.
  - `br_valid` held during FLUSH → accepted only on the first IDLE edge.
- **Saturation:** force 65537 taken branches → `stat_taken` and `stat_resolved` hold at 0xFFFF.
